// File: rtl/mem_pkg.sv
// Shared definitions for the memory requester: op codes, FSM states,
// default widths and a small op-legality helper.
package mem_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int HOLD_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF     = 8;

  typedef enum logic [2:0] {
    OP_WAIT  = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_CLEAR = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Only read, write and clear reach the memory; everything else is an error.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/mem_requester_if.sv
// User-side request/response handshake of the memory requester.
// master = user logic issuing requests, slave = the requester itself.
interface mem_requester_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_requester.sv
// Memory requester: accepts one request at a time from user logic, drives
// the memory operation lines for a fixed number of hold cycles, waits for
// the memory done pulse (bounded by a timeout) and returns a one-cycle
// response. Every output is a register loaded from the next-state logic.
module mem_requester
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_requester_if.slave    req_bus,
  output logic              busy,
  output logic [2:0]        mem_operation,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done
);

  // One counter serves both the hold phase and the wait timeout, so it must
  // reach the larger of the two terminal values.
  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        op_r, op_s;

  logic              ready_s;
  logic              busy_s;
  logic [2:0]        mem_op_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rdata_s;
  logic              valid_s;
  logic              err_s;
  logic              accept_s;

  assign accept_s = req_bus.req_valid & req_bus.req_ready;

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    mem_op_s = mem_operation;
    addr_s   = mem_address;
    wdata_s  = mem_data_in;
    rdata_s  = req_bus.resp_rdata;
    valid_s  = 1'b0;
    err_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // A stray mem_done here (e.g. left over from an operation cut
        // short by reset) is deliberately not looked at.
        if (accept_s) begin
          op_s  = req_bus.req_op;
          cnt_s = '0;
          if (op_is_legal(req_bus.req_op)) begin
            mem_op_s = req_bus.req_op;
            addr_s   = req_bus.req_addr;
            wdata_s  = req_bus.req_wdata;
            state_s  = ISSUE;
          end else begin
            valid_s = 1'b1;
            err_s   = 1'b1;
            state_s = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ISSUE: begin
        // Memory samples the op on wake-up and again on decode, so it is
        // held for the full hold window; done is ignored meanwhile.
        if (cnt_r == HOLD_LAST) begin
          mem_op_s = OP_WAIT;
          cnt_s    = '0;
          state_s  = WAIT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      WAIT: begin
        // Done takes priority over a timeout expiring in the same cycle.
        if (mem_done) begin
          if (op_r == OP_READ) begin
            rdata_s = mem_data_out;
          end else begin
            rdata_s = req_bus.resp_rdata;
          end
          valid_s = 1'b1;
          err_s   = 1'b0;
          cnt_s   = '0;
          state_s = RESP;
        end else if (cnt_r == TMO_LAST) begin
          valid_s = 1'b1;
          err_s   = 1'b1;
          cnt_s   = '0;
          state_s = RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      RESP: begin
        cnt_s   = '0;
        state_s = IDLE;
      end

      default: begin
        mem_op_s = OP_WAIT;
        cnt_s    = '0;
        state_s  = IDLE;
      end
    endcase

    ready_s = (state_s == IDLE);
    busy_s  = (state_s != IDLE);
  end

  // State, shared counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      cnt_r              <= '0;
      op_r               <= 3'd0;
      req_bus.req_ready  <= 1'b1;
      req_bus.resp_valid <= 1'b0;
      req_bus.resp_err   <= 1'b0;
      req_bus.resp_rdata <= '0;
      busy               <= 1'b0;
      mem_operation      <= 3'd0;
      mem_address        <= '0;
      mem_data_in        <= '0;
    end else begin
      state_r            <= state_s;
      cnt_r              <= cnt_s;
      op_r               <= op_s;
      req_bus.req_ready  <= ready_s;
      req_bus.resp_valid <= valid_s;
      req_bus.resp_err   <= err_s;
      req_bus.resp_rdata <= rdata_s;
      busy               <= busy_s;
      mem_operation      <= mem_op_s;
      mem_address        <= addr_s;
      mem_data_in        <= wdata_s;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester: a behavioural 16-entry memory (or a
// silent stub) answers the requester, a reference model predicts each
// response at accept time, and a negedge monitor checks every resp_valid.
module tb_mem_requester;

  localparam int DW = 16;
  localparam int AW = 4;

  // Accept edge to the edge that raises resp_valid.
  localparam int LAT_OK  = 4;   // hold 2 + memory done after 2 more edges
  localparam int LAT_ILL = 0;   // straight to the response
  localparam int LAT_TMO = 10;  // 2 hold + 8 timeout

  logic          clk;
  logic          rst_n;
  logic          busy;
  logic [2:0]    mem_operation;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_done;

  mem_requester_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_requester #(.DATA_W(DW), .ADDR_W(AW), .HOLD_CYCLES(2), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_bus      (bus),
    .busy         (busy),
    .mem_operation(mem_operation),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_done     (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- responder: 3-edge memory or silent stub ----------------
  logic          use_stub;
  logic          stub_done;
  logic          mem_done_m;
  logic [1:0]    mst;
  logic [2:0]    lop;
  logic [AW-1:0] laddr;
  logic [DW-1:0] ldata;
  logic [DW-1:0] store [16];

  initial begin
    mst        = 2'd0;
    mem_done_m = 1'b0;
    mem_data_out = '0;
    lop = 3'd0; laddr = '0; ldata = '0;
    for (int i = 0; i < 16; i++) store[i] = '0;
  end

  assign mem_done = use_stub ? stub_done : mem_done_m;

  always @(posedge clk) begin
    mem_done_m <= 1'b0;
    if (use_stub) begin
      mst <= 2'd0;
    end else begin
      case (mst)
        2'd0: if (mem_operation != 3'd0) mst <= 2'd1;
        2'd1: begin
          if (mem_operation != 3'd0) begin
            lop <= mem_operation; laddr <= mem_address; ldata <= mem_data_in;
            mst <= 2'd2;
          end else begin
            mst <= 2'd0;
          end
        end
        2'd2: begin
          if (lop == 3'd1) mem_data_out <= store[laddr];
          else if (lop == 3'd2) store[laddr] <= ldata;
          else if (lop == 3'd3) for (int i = 0; i < 16; i++) store[i] <= '0;
          mem_done_m <= 1'b1;
          mst <= 2'd0;
        end
        default: mst <= 2'd0;
      endcase
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nz_cnt = 0, exp_nz = 0;
  int   done_cnt = 0, exp_done = 0;
  int   busy_cnt = 0, exp_busy = 0;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] model_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Record accept edges (pre-edge values of valid and ready).
  always @(posedge clk) begin
    if (rst_n && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    cyc++;
  end

  // Monitor: pops the expected response whenever resp_valid is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_operation != 3'd0) nz_cnt++;
      if (busy) busy_cnt++;
      if (mem_done_m) done_cnt++;
      chk("ready_vs_busy", {31'd0, bus.req_ready}, {31'd0, ~busy});
      if (bus.resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_err",   {31'd0, bus.resp_err}, {31'd0, e.err});
          chk("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e.rdata});
          chk("resp_lat",   32'(cyc - a - 1), 32'(e.lat));
        end
      end
    end
  end

  // Reference model: outcome of a request from the operation rules alone.
  task automatic predict(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    exp_t e;
    if (!(op inside {3'd1, 3'd2, 3'd3})) begin
      e = '{err: 1'b1, rdata: model_rdata, lat: LAT_ILL};
      exp_busy += 1;
    end else if (use_stub) begin
      e = '{err: 1'b1, rdata: model_rdata, lat: LAT_TMO};
      exp_nz += 2; exp_busy += 11;
    end else begin
      if (op == 3'd1) model_rdata = ref_mem[addr];
      else if (op == 3'd2) ref_mem[addr] = wd;
      else for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      e = '{err: 1'b0, rdata: model_rdata, lat: LAT_OK};
      exp_nz += 2; exp_done += 1; exp_busy += 5;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input bit keep);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("send_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    end else begin
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk);
      predict(op, addr, wd);
      if (!keep) begin @(negedge clk); bus.req_valid = 1'b0; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; use_stub = 1'b0; stub_done = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",  {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_valid",  {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_err",    {31'd0, bus.resp_err}, 32'd0);
    chk("rst_rdata",  {16'd0, bus.resp_rdata}, 32'd0);
    chk("rst_memop",  {29'd0, mem_operation}, 32'd0);
    chk("rst_addr",   {28'd0, mem_address}, 32'd0);
    chk("rst_wdata",  {16'd0, mem_data_in}, 32'd0);

    // Write then read back addr 3.
    send(3'd2, 4'd3, 16'h0005, 1'b0);
    chk("wr_memop", {29'd0, mem_operation}, 32'd2);
    chk("wr_addr",  {28'd0, mem_address}, 32'd3);
    chk("wr_data",  {16'd0, mem_data_in}, 32'h0005);
    drain();
    send(3'd1, 4'd3, 16'h0000, 1'b0);
    drain();

    // Writes at both address extremes, clear, then read both back.
    send(3'd2, 4'd0, 16'hBEEF, 1'b0);
    send(3'd2, 4'd15, 16'h1234, 1'b0);
    send(3'd1, 4'd15, 16'h0000, 1'b0);
    send(3'd3, 4'd9, 16'hFFFF, 1'b0);
    send(3'd1, 4'd0, 16'h0000, 1'b0);
    send(3'd1, 4'd15, 16'h0000, 1'b0);
    drain();

    // Illegal op codes.
    send(3'd0, 4'd1, 16'h1111, 1'b0);
    send(3'd5, 4'd2, 16'h2222, 1'b0);
    send(3'd7, 4'd2, 16'h2222, 1'b0);
    drain();

    // Back-to-back reads with req_valid held high throughout.
    send(3'd2, 4'd6, 16'hA5A5, 1'b0);
    for (int i = 0; i < 4; i++) send(3'd1, 4'(6 + (i % 2)), 16'h0000, 1'b1);
    @(negedge clk); bus.req_valid = 1'b0;
    drain();

    // Randomized mix against the reference model.
    for (int i = 0; i < 30; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Timeout against a memory that never answers.
    use_stub = 1'b1;
    send(3'd1, 4'd4, 16'h0000, 1'b0);
    begin
      int n = 0;
      while (!bus.resp_valid && n < 30) begin @(negedge clk); n++; end
      chk("tmo_resp_seen", {31'd0, bus.resp_valid}, 32'd1);
      @(negedge clk);
      chk("tmo_ready_next", {31'd0, bus.req_ready}, 32'd1);
    end
    drain();
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));

    // Reset while waiting for done, then a late done from the stub.
    send(3'd1, 4'd5, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy",  {31'd0, busy}, 32'd1);
    chk("pre_rst_memop", {29'd0, mem_operation}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    exp_q.delete(); acc_q.delete();
    model_rdata = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    stub_done = 1'b1;
    @(negedge clk);
    stub_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("late_done_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("late_done_busy",  {31'd0, busy}, 32'd0);
    end
    use_stub = 1'b0;
    send(3'd2, 4'd8, 16'h0C0C, 1'b0);
    send(3'd1, 4'd8, 16'h0000, 1'b0);
    drain();

    chk("memop_nonzero_cycles", 32'(nz_cnt), 32'(exp_nz));
    chk("mem_done_count", 32'(done_cnt), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
